// File: rtl/alu32_pkg.sv
// rtl/alu32_pkg.sv - shared word width and word type for the alu32 server
package alu32_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/equal32.sv
// rtl/equal32.sv - 32-bit bitwise equality comparator
module equal32
    import alu32_pkg::*;
(
    input  word_t x,
    input  word_t y,
    output logic  equal
);

    assign equal = (x == y);

endmodule

// File: rtl/equal32_arbiter.sv
// rtl/equal32_arbiter.sv - round-robin share of one equal32 among N_REQ requesters
module equal32_arbiter
    import alu32_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ),
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  word_t [N_REQ-1:0]     req_x,
    input  word_t [N_REQ-1:0]     req_y,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic                  rsp_equal,
    output logic [CNT_W-1:0]      cmp_count,
    output logic [CNT_W-1:0]      match_count
);

    logic              s1_valid_q, s1_valid_d;
    logic [ID_W-1:0]   s1_id_q, s1_id_d;
    word_t             s1_x_q, s1_x_d;
    word_t             s1_y_q, s1_y_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic              rsp_equal_q, rsp_equal_d;
    logic [CNT_W-1:0]  cmp_count_q, cmp_count_d;
    logic [CNT_W-1:0]  match_count_q, match_count_d;

    logic              s1_adv, s2_adv, accept, gnt_any, cmp_equal;
    logic [ID_W-1:0]   gnt_id;
    logic [N_REQ-1:0]  grant;

    equal32 u_equal32 (
        .x     (s1_x_q),
        .y     (s1_y_q),
        .equal (cmp_equal)
    );

    assign s2_adv = !rsp_valid_q || rsp_ready;
    assign s1_adv = !s1_valid_q || s2_adv;
    assign accept = gnt_any && s1_adv;

    // First valid requester at or after rr_ptr, wrapping modulo N_REQ
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        grant   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!gnt_any && req_valid[(int'(rr_ptr_q) + k) % N_REQ]) begin
                gnt_any = 1'b1;
                gnt_id  = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
            end
        end
        grant[gnt_id] = gnt_any;
    end

    assign req_ready = grant & {N_REQ{s1_adv && !rst}};

    always_comb begin
        s1_valid_d    = s1_valid_q;
        s1_id_d       = s1_id_q;
        s1_x_d        = s1_x_q;
        s1_y_d        = s1_y_q;
        rr_ptr_d      = rr_ptr_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_id_d      = rsp_id_q;
        rsp_equal_d   = rsp_equal_q;
        cmp_count_d   = cmp_count_q;
        match_count_d = match_count_q;

        if (s1_adv) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_id_d  = gnt_id;
                s1_x_d   = req_x[gnt_id];
                s1_y_d   = req_y[gnt_id];
                rr_ptr_d = ID_W'((int'(gnt_id) + 1) % N_REQ);
            end
        end

        if (s2_adv) begin
            rsp_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                rsp_id_d    = s1_id_q;
                rsp_equal_d = cmp_equal;
            end
        end

        // Statistics saturate at all-ones so a long debug run never wraps
        if (rsp_valid_q && rsp_ready) begin
            if (cmp_count_q != '1) begin
                cmp_count_d = cmp_count_q + CNT_W'(1);
            end
            if (rsp_equal_q && (match_count_q != '1)) begin
                match_count_d = match_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s1_id_q       <= '0;
            s1_x_q        <= '0;
            s1_y_q        <= '0;
            rr_ptr_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_equal_q   <= 1'b0;
            cmp_count_q   <= '0;
            match_count_q <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_id_q       <= s1_id_d;
            s1_x_q        <= s1_x_d;
            s1_y_q        <= s1_y_d;
            rr_ptr_q      <= rr_ptr_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_equal_q   <= rsp_equal_d;
            cmp_count_q   <= cmp_count_d;
            match_count_q <= match_count_d;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_equal   = rsp_equal_q;
    assign cmp_count   = cmp_count_q;
    assign match_count = match_count_q;

endmodule

// File: tb/tb_equal32_arbiter.sv
// tb/tb_equal32_arbiter.sv - directed bench for equal32_arbiter
module tb_equal32_arbiter;

    logic              clk;
    logic              rst;
    logic [3:0]        req_valid;
    logic [3:0]        req_ready;
    logic [3:0][31:0]  req_x;
    logic [3:0][31:0]  req_y;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic              rsp_equal;
    logic [3:0]        cmp_count;
    logic [3:0]        match_count;

    int n_checks;
    int n_errors;

    equal32_arbiter #(
        .N_REQ (4),
        .CNT_W (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_x       (req_x),
        .req_y       (req_y),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_equal   (rsp_equal),
        .cmp_count   (cmp_count),
        .match_count (match_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_x     = '0;
        req_y     = '0;
        rsp_ready = 1'b1;

        settle();
        check("ready_in_reset", 32'(req_ready), 32'h0);
        tick();
        tick();
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_id", 32'(rsp_id), 32'h0);
        check("rst_rsp_equal", 32'(rsp_equal), 32'h0);
        check("rst_cmp", 32'(cmp_count), 32'h0);
        check("rst_match", 32'(match_count), 32'h0);
        req_valid = 4'b0000;
        rst = 1'b0;
        tick();

        // single request from requester 2
        req_valid = 4'b0100;
        req_x[2] = 32'hA5A5_A5A5;
        req_y[2] = 32'hA5A5_A5A5;
        settle();
        check("single_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b0000;
        check("single_lat0", 32'(rsp_valid), 32'h0);
        tick();
        check("single_valid", 32'(rsp_valid), 32'h1);
        check("single_id", 32'(rsp_id), 32'h2);
        check("single_eq", 32'(rsp_equal), 32'h1);
        tick();
        check("single_cmp", 32'(cmp_count), 32'h1);
        check("single_match", 32'(match_count), 32'h1);
        check("single_drain", 32'(rsp_valid), 32'h0);

        // 1-bit difference on requester 3 (pointer sits at 3)
        req_valid = 4'b1000;
        req_x[3] = 32'h1234_5678;
        req_y[3] = 32'h1234_5679;
        settle();
        check("diff_ready", 32'(req_ready), 32'h8);
        tick();
        req_valid = 4'b0000;
        tick();
        check("diff_id", 32'(rsp_id), 32'h3);
        check("diff_eq", 32'(rsp_equal), 32'h0);
        tick();
        check("diff_cmp", 32'(cmp_count), 32'h2);
        check("diff_match", 32'(match_count), 32'h1);

        // round robin: even requesters equal, odd requesters differ
        for (int i = 0; i < 4; i++) begin
            req_x[i] = 32'(i);
            req_y[i] = (i % 2 == 0) ? 32'(i) : 32'(i + 100);
        end
        req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            settle();
            check($sformatf("rr_ready_%0d", c), 32'(req_ready), 32'(1 << (c % 4)));
            tick();
            if (c >= 1) begin
                check($sformatf("rr_valid_%0d", c), 32'(rsp_valid), 32'h1);
                check($sformatf("rr_id_%0d", c), 32'(rsp_id), 32'((c - 1) % 4));
                check($sformatf("rr_eq_%0d", c), 32'(rsp_equal), 32'(((c - 1) % 2) == 0));
            end
        end
        req_valid = 4'b0000;
        tick();
        check("rr_last_id", 32'(rsp_id), 32'h3);
        check("rr_last_eq", 32'(rsp_equal), 32'h0);
        tick();
        check("rr_drain", 32'(rsp_valid), 32'h0);
        check("rr_cmp", 32'(cmp_count), 32'd10);
        check("rr_match", 32'(match_count), 32'd5);

        // MSB-only operands equal on requester 1
        req_valid = 4'b0010;
        req_x[1] = 32'h8000_0000;
        req_y[1] = 32'h8000_0000;
        settle();
        check("msb_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'b0000;
        tick();
        check("msb_id", 32'(rsp_id), 32'h1);
        check("msb_eq", 32'(rsp_equal), 32'h1);
        tick();
        check("msb_cmp", 32'(cmp_count), 32'd11);
        check("msb_match", 32'(match_count), 32'd6);

        // backpressure with requesters 0..2, pointer at 2
        rsp_ready = 1'b0;
        req_x[0] = 32'h5;  req_y[0] = 32'h6;
        req_x[1] = 32'h11; req_y[1] = 32'h11;
        req_x[2] = 32'h22; req_y[2] = 32'h22;
        req_valid = 4'b0111;
        settle();
        check("bp_ready0", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b0011;
        settle();
        check("bp_ready1", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0010;
        for (int c = 2; c < 5; c++) begin
            settle();
            check($sformatf("bp_blocked_%0d", c), 32'(req_ready), 32'h0);
            check($sformatf("bp_hold_v_%0d", c), 32'(rsp_valid), 32'h1);
            check($sformatf("bp_hold_id_%0d", c), 32'(rsp_id), 32'h2);
            check($sformatf("bp_hold_eq_%0d", c), 32'(rsp_equal), 32'h1);
            tick();
        end
        check("bp_cmp_held", 32'(cmp_count), 32'd11);
        rsp_ready = 1'b1;
        settle();
        check("bp_release_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'b0000;
        check("bp_r1_id", 32'(rsp_id), 32'h0);
        check("bp_r1_eq", 32'(rsp_equal), 32'h0);
        tick();
        check("bp_r2_id", 32'(rsp_id), 32'h1);
        check("bp_r2_eq", 32'(rsp_equal), 32'h1);
        tick();
        check("bp_drain", 32'(rsp_valid), 32'h0);
        check("bp_cmp", 32'(cmp_count), 32'd14);
        check("bp_match", 32'(match_count), 32'd8);

        // saturation: 20 more equal results on 4-bit counters
        for (int i = 0; i < 4; i++) begin
            req_x[i] = 32'hCAFE_0000 + 32'(i);
            req_y[i] = 32'hCAFE_0000 + 32'(i);
        end
        req_valid = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            tick();
        end
        req_valid = 4'b0000;
        tick();
        tick();
        tick();
        check("sat_drain", 32'(rsp_valid), 32'h0);
        check("sat_cmp", 32'(cmp_count), 32'd15);
        check("sat_match", 32'(match_count), 32'd15);

        // reset with both stages full
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_y[i] = ~req_x[i];
        end
        req_valid = 4'b1111;
        tick();
        tick();
        settle();
        check("mid_full_v", 32'(rsp_valid), 32'h1);
        check("mid_full_ready", 32'(req_ready), 32'h0);
        rst = 1'b1;
        settle();
        check("mid_rst_ready", 32'(req_ready), 32'h0);
        tick();
        check("mid_rsp_valid", 32'(rsp_valid), 32'h0);
        check("mid_cmp", 32'(cmp_count), 32'h0);
        check("mid_match", 32'(match_count), 32'h0);
        rst = 1'b0;
        rsp_ready = 1'b1;
        settle();
        check("mid_ptr_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0000;
        tick();
        check("mid_new_v", 32'(rsp_valid), 32'h1);
        check("mid_new_id", 32'(rsp_id), 32'h0);
        tick();
        check("mid_no_stale", 32'(rsp_valid), 32'h0);
        check("mid_cmp_one", 32'(cmp_count), 32'h1);

        // idle requesters keep the pointer (now 1)
        tick();
        tick();
        check("idle_ready", 32'(req_ready), 32'h0);
        check("idle_valid", 32'(rsp_valid), 32'h0);
        req_valid = 4'b1001;
        settle();
        check("idle_ptr_ready", 32'(req_ready), 32'h8);
        req_valid = 4'b0000;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/equal32_arbiter.md
# equal32_arbiter

Round-robin arbiter that shares one `equal32` comparator among `N_REQ` requesters in the alu32 server. Requesters hand in operand pairs over valid/ready handshakes. The block registers the granted pair, compares it, and returns a tagged result on one backpressured response port. It also keeps saturating statistics counters for debug readout.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `ID_W`, `$clog2(N_REQ)`, requester-id width
- `CNT_W`, 16, statistics counter width
- `clk`  in  1  clock; all logic on the rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req_valid`  in  `N_REQ`  request i holds a valid operand pair
- `req_ready`  out  `N_REQ`  request i accepted this cycle when `req_valid[i] && req_ready[i]`
- `req_x`  in  `N_REQ`×32  operand x per requester
- `req_y`  in  `N_REQ`×32  operand y per requester
- `rsp_valid`  out  1  result available
- `rsp_ready`  in  1  consumer accepts the result
- `rsp_id`  out  `ID_W`  requester index of the result
- `rsp_equal`  out  1  1 iff x == y, bitwise over all 32 bits
- `cmp_count`  out  `CNT_W`  number of results delivered, saturating
- `match_count`  out  `CNT_W`  number of delivered results with `rsp_equal` = 1, saturating

## Operation
- **Pipeline stage S1:** operand register holding `s1_valid`, `s1_id`, `s1_x`, `s1_y`.
- **Pipeline stage S2:** result register holding `rsp_valid`, `rsp_id`, `rsp_equal`. `rsp_equal` is the `equal32` output on `s1_x`/`s1_y`.
- **Stall rules:**
  - `s2_adv = !rsp_valid || rsp_ready`
  - `s1_adv = !s1_valid || s2_adv`
- **Grant:** combinational, one-hot. The granted requester is the first i with `req_valid[i]`, searching from `rr_ptr` upward modulo `N_REQ`. `req_ready[i] = grant[i] && s1_adv`, so at most one `req_ready` bit is high.
- **Accepted request:** S1 loads the granted x, y and id. `rr_ptr` becomes (granted index + 1) mod `N_REQ`.
- **No acceptance:** `rr_ptr` is unchanged.
- **S1 → S2 transfer:** when `s1_valid && s2_adv`, S2 loads id and the comparison result and sets `rsp_valid` to 1.
- **Response accepted, no new S1 data:** when `rsp_valid && rsp_ready` with no S1 transfer, `rsp_valid` goes to 0.
- **Response hold:** while `rsp_valid && !rsp_ready`, `rsp_id` and `rsp_equal` stay stable.
- **Counters:** on each response handshake:
  - `cmp_count` increments.
  - `match_count` increments if `rsp_equal` = 1.
  - Both saturate at all-ones and never wrap.
- **Requester contract:** requesters must hold `req_x`/`req_y` stable while valid and not ready. The block does not check this.

## Timing
- **Reset values:** `rsp_valid`=0, `rsp_id`=0, `rsp_equal`=0, `s1_valid`=0, `rr_ptr`=0, `cmp_count`=0, `match_count`=0.
- **During reset:** `req_ready` = 0.
- **Latency:** request handshake at edge n → `rsp_valid` high after edge n+1.
- **Throughput:** one request per cycle with `rsp_ready` held high.
- **Full backpressure:** `rsp_ready`=0 with S1 and S2 both full → all `req_ready` = 0. Contents of both stages are held with no loss and no duplication.
- **Simultaneous events:** a response handshake plus an S1→S2 transfer in the same cycle is legal. S2 reloads and `rsp_valid` stays 1.
- **Reset mid-operation:** in-flight S1/S2 data is discarded. No response is issued for it. Counters clear.
- **Idle requesters:** `req_valid` = 0 on all inputs → no grant, `rr_ptr` holds, S1 drains.

## Structure
- **Package `alu32_pkg`:** holds `WORD_W` = 32 and `typedef logic [WORD_W-1:0] word_t`.
- **Sub-module:** exactly one instance of the existing `equal32` (ports `x`, `y`, `equal`), driven from `s1_x`/`s1_y`.
- **Arbiter logic:** the round-robin logic is an internal `always_comb` in this module, not a separate sub-module.

## Test plan
- **Single request:** after reset, requester 2 sends x=`32'hA5A5_A5A5`, y=`32'hA5A5_A5A5` with `rsp_ready`=1 → `rsp_valid` two cycles later, `rsp_id`=2, `rsp_equal`=1, `cmp_count`=1, `match_count`=1.
- **Round-robin fairness:** all 4 requesters hold valid for 8 cycles with `rsp_ready`=1 → grants in order 0,1,2,3,0,1,2,3, and ids come back in the same order.
- **1-bit difference:** x=`32'h1234_5678`, y=`32'h1234_5679` → `rsp_equal`=0, `match_count` unchanged. Then x=`32'h8000_0000`, y=`32'h8000_0000` → `rsp_equal`=1.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles with 3 requesters valid → exactly 2 requests accepted, `req_ready` all 0 afterwards, and the first response stays stable. Releasing `rsp_ready` delivers responses with no loss and no duplication.
- **Saturation:** preload `CNT_W`=4 and issue 20 equal requests → `cmp_count` and `match_count` stop at 15.
- **Reset mid-flight:** assert `rst` with S1 and S2 full → next cycle `rsp_valid`=0, counters 0, and `rr_ptr`=0, shown by the next grant going to requester 0.
